reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: DATA_W, default 64, register and data-port width in bits.
REQ-002 Parameter: NUM_REGS, fixed at 32, register count; the zero register is index 31 (X31/XZR).
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: RegWrite  input  1  write enable; drives the enable of the 5:32 write-select decode.
REQ-006 Port: WriteRegister  input  5  destination register index.
REQ-007 Port: WriteData  input  DATA_W  data to write.
REQ-008 Port: ReadRegister1  input  5  read port 1 index.
REQ-009 Port: ReadRegister2  input  5  read port 2 index.
REQ-010 Port: ReadData1  output  DATA_W  read port 1 data.
REQ-011 Port: ReadData2  output  DATA_W  read port 2 data.
REQ-012 Clocking is decided: one clock (clk); reset (reset) is asynchronous and active-high.

Function
REQ-013 Storage SHALL be 31 writable DATA_W-bit registers, X0..X30, each enabled by one decoded write-select line.
REQ-014 Write-select SHALL be a one-hot 5:32 decode of WriteRegister gated by RegWrite; at most one line SHALL be active, and none SHALL be active when RegWrite=0.
REQ-015 On a rising clk edge with RegWrite=1 and WriteRegister!=31, register[WriteRegister] SHALL load WriteData; all other registers SHALL hold.
REQ-016 A write to index 31 SHALL be discarded; X31 SHALL always read as 0.
REQ-017 ReadData1/ReadData2 SHALL be combinational 32:1 selections of the indexed register, with zero-cycle latency relative to the read index.
REQ-018 Both read ports SHALL be independent; the same index on both ports SHALL return identical data.
REQ-019 A same-cycle read and write to one register SHALL follow REQ-027/REQ-028.
REQ-020 Back-to-back writes to one register on consecutive edges SHALL leave the last value written.
REQ-021 X/Z on WriteRegister while RegWrite=0 SHALL NOT corrupt any register.

Reset
REQ-022 While reset=1, X0..X30 SHALL be forced to 0 immediately, without waiting for clk.
REQ-023 While reset=1, ReadData1 and ReadData2 SHALL read 0 for every index.
REQ-024 reset SHALL override any write in the same cycle; no write SHALL take effect on an edge where reset=1.
REQ-025 Reset asserted mid-sequence SHALL clear all state; the first write after deassertion SHALL behave per REQ-015.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN SHALL select write-to-read bypass behaviour.
REQ-027 With REGFILE_BYPASS_EN defined: when RegWrite=1, WriteRegister!=31, and ReadRegisterN==WriteRegister, ReadDataN SHALL equal WriteData combinationally, before the edge.
REQ-028 Without REGFILE_BYPASS_EN: ReadDataN SHALL return the old register value until the rising edge, then the new value.
REQ-029 In both builds, index 31 SHALL never be bypassed and SHALL read 0.

Verification
REQ-030 The bench SHALL cover: reset=1 with all 32 indices read on both ports -> every read returns 0; reset=1 with RegWrite=1 and a clk edge -> no register changes.
REQ-031 The bench SHALL cover: write X5=64'h0123_4567_89AB_CDEF, then read ReadRegister1=5, ReadRegister2=5 -> both ports return 64'h0123_4567_89AB_CDEF; X4 and X6 remain 0.
REQ-032 The bench SHALL cover: RegWrite=1, WriteRegister=31, WriteData=all-ones, then read 31 -> returns 0; no other register changes.
REQ-033 The bench SHALL cover: RegWrite=0, WriteRegister=7, WriteData=64'hDEAD, one edge, then read 7 -> returns its prior value.
REQ-034 The bench SHALL cover: write X10=64'hAA, then in the next cycle write X10=64'hBB while reading 10 -> the read returns 64'hBB pre-edge with REGFILE_BYPASS_EN, or 64'hAA pre-edge and 64'hBB post-edge without it.
REQ-035 The bench SHALL cover: write X0..X30 with value=index+1, then assert reset asynchronously between edges -> all reads return 0 immediately; after deassertion, write X3=64'h3 -> only X3 is nonzero.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: 31 x DATA_W register file with hardwired zero register X31, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   regs_q [NUM_REGS-1];
  logic [DATA_W-1:0]   rf     [NUM_REGS];
  logic                byp1;
  logic                byp2;
  // RegWrite gates the decode first, so an unknown index with RegWrite=0 selects nothing
  assign wr_sel = RegWrite ? {{(NUM_REGS-1){1'b0}}, 1'b1} << WriteRegister : '0;
  for (genvar r = 0; r < NUM_REGS - 1; r++) begin : g_reg
    always_ff @(posedge clk or posedge reset)
      if (reset) regs_q[r] <= '0;
      else if (wr_sel[r]) regs_q[r] <= WriteData;
  end
  always_comb begin
    for (int i = 0; i < NUM_REGS - 1; i++) rf[i] = regs_q[i];
    rf[NUM_REGS-1] = '0;
  end
`ifdef REGFILE_BYPASS_EN
  assign byp1 = RegWrite && WriteRegister != 5'd31 && ReadRegister1 == WriteRegister;
  assign byp2 = RegWrite && WriteRegister != 5'd31 && ReadRegister2 == WriteRegister;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  assign ReadData1 = reset ? '0 : byp1 ? WriteData : rf[ReadRegister1];
  assign ReadData2 = reset ? '0 : byp2 ? WriteData : rf[ReadRegister2];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file (default and REGFILE_BYPASS_EN builds).
module tb_reg_file;
  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;
  int checks = 0;
  int failures = 0;

  reg_file #(.DATA_W(64)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] idx, input logic [63:0] d);
    @(negedge clk);
    RegWrite = 1'b1;
    WriteRegister = idx;
    WriteData = d;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [4:0] b,
                    input logic [63:0] ea, input logic [63:0] eb);
    ReadRegister1 = a;
    ReadRegister2 = b;
    #1;
    check({tag, "_rd1"}, ReadData1, ea);
    check({tag, "_rd2"}, ReadData2, eb);
  endtask

  initial begin
    reset = 1'b1;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    #2;
    for (int i = 0; i < 32; i++) rd("reset_all", 5'(i), 5'(31 - i), 64'h0, 64'h0);
    wr(5'd5, '1);
    @(negedge clk);
    reset = 1'b0;
    rd("reset_blocks_write", 5'd5, 5'd4, 64'h0, 64'h0);

    wr(5'd5, 64'h0123_4567_89AB_CDEF);
    rd("x5_both", 5'd5, 5'd5, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    rd("x4_x6", 5'd4, 5'd6, 64'h0, 64'h0);

    wr(5'd31, '1);
    rd("xzr_write", 5'd31, 5'd5, 64'h0, 64'h0123_4567_89AB_CDEF);
    rd("xzr_neighbors", 5'd30, 5'd0, 64'h0, 64'h0);

    wr(5'd7, 64'h77);
    @(negedge clk);
    WriteRegister = 5'd7;
    WriteData = 64'hDEAD;
    @(posedge clk);
    #1;
    rd("we_low", 5'd7, 5'd31, 64'h77, 64'h0);
    @(negedge clk);
    WriteRegister = 5'bxxxxx;
    WriteData = '1;
    @(posedge clk);
    #1;
    rd("x_index_we_low", 5'd5, 5'd7, 64'h0123_4567_89AB_CDEF, 64'h77);

    wr(5'd10, 64'hAA);
    @(negedge clk);
    RegWrite = 1'b1;
    WriteRegister = 5'd10;
    WriteData = 64'hBB;
`ifdef REGFILE_BYPASS_EN
    rd("raw_pre_edge", 5'd10, 5'd31, 64'hBB, 64'h0);
`else
    rd("raw_pre_edge", 5'd10, 5'd31, 64'hAA, 64'h0);
`endif
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    rd("raw_post_edge", 5'd10, 5'd10, 64'hBB, 64'hBB);

    for (int i = 0; i < 31; i++) wr(5'(i), 64'(i + 1));
    rd("fill_lo", 5'd0, 5'd1, 64'h1, 64'h2);
    rd("fill_hi", 5'd30, 5'd31, 64'd31, 64'h0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) rd("async_reset", 5'(i), 5'(i), 64'h0, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    wr(5'd3, 64'h3);
    for (int i = 0; i < 32; i++)
      rd("after_reset", 5'(i), 5'(31 - i), (i == 3) ? 64'h3 : 64'h0, (i == 28) ? 64'h3 : 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
